xdma_h2c_udp_meta_splitter: RTL and testbench
=============================================

# xdma_h2c_udp_meta_splitter

Splits the XDMA H2C AXI-Stream into a UDP metadata stream and a payload stream for the UDP/IP/ARP/Ethernet CMAC TX path. Each host packet begins with one 512-bit header beat carrying destination IP, ports and payload length, followed by the payload beats. The block sits between the H2C cross-die buffer FIFO and the UDP wrapper's TX input. It validates the header, trims the payload to the declared length, and drops malformed packets.

## Interface
- DATA_WIDTH, 512, tdata width in bits.
- KEEP_WIDTH, 64, tkeep width (DATA_WIDTH/8).
- MAX_PAYLOAD_BYTES, 8192, largest legal payload_len.

Reset is asynchronous and active-high.

- xdma_clk  in  1  sole clock.
- xdma_reset  in  1  asynchronous active-high reset.
- s_axis_tvalid/tready/tlast  in/out/in  1  H2C input handshake.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tkeep  in  KEEP_WIDTH  contiguous-from-LSB byte enables.
- meta_valid  out  1  metadata available.
- meta_ready  in  1  metadata consumed.
- meta_dst_ip  out  32  header bits [31:0].
- meta_dst_port  out  16  header bits [47:32].
- meta_src_port  out  16  header bits [63:48].
- meta_len  out  16  header bits [79:64], payload bytes.
- m_axis_tvalid/tready/tlast  out/in/out  1  payload output handshake.
- m_axis_tdata  out  DATA_WIDTH  payload data.
- m_axis_tkeep  out  KEEP_WIDTH  payload byte enables.
- m_axis_tuser  out  1  length-error flag; valid on the tlast beat only.
- drop_cnt  out  16  dropped-packet count (stats build only).
- len_err_cnt  out  16  short-packet count (stats build only).

## Operation
- FSM states: HDR, PAY, DROP. Reset enters HDR.
- **HDR:**
  - s_axis_tready = ~meta_valid.
  - On an accepted beat, the header is legal when tlast=0, 0 < len <= MAX_PAYLOAD_BYTES.
  - Legal header: latch the meta fields, set meta_valid, clear byte_cnt (16 bit), go to PAY.
  - Illegal header with tlast=0: go to DROP, drop_cnt++.
  - Illegal header with tlast=1: stay in HDR, drop_cnt++.
- **PAY:**
  - s_axis_tready = ~m_axis_tvalid | m_axis_tready (single output register).
  - Each accepted beat is copied to the output register with byte_cnt += popcount(tkeep). The popcount is 7 bits wide, zero-extended.
  - Beat where byte_cnt_next >= meta_len:
    - Output tlast=1 and tuser=0.
    - tkeep is trimmed so that the beat's bytes equal meta_len - byte_cnt.
    - If the input beat has tlast=1, go to HDR; otherwise go to DROP (the excess is discarded, with no counter change).
  - Input tlast with byte_cnt_next < meta_len: output tlast=1, tuser=1, len_err_cnt++, go to HDR.
- **DROP:** s_axis_tready=1. Beats are discarded; on tlast go to HDR.
- The meta handshake is independent of payload flow. meta_valid clears on meta_valid & meta_ready.
  - A new header cannot be accepted until the previous meta has been taken.
  - Payload may stream before the meta has been taken.
- Counters saturate at 0xFFFF.
- Simultaneous meta_ready and header acceptance in HDR is impossible, because tready requires ~meta_valid.

## Timing
- Meta: meta_valid rises the cycle after header acceptance.
- Payload: one-cycle latency input-to-output. Full throughput of 1 beat/cycle, with no bubble between packets beyond the single header beat.
- Output register holds steady while m_axis_tvalid & ~m_axis_tready. This is AXI-Stream compliant; valid never depends on ready.
- Reset values:
  - meta_valid=0, m_axis_tvalid=0, s_axis_tready=0 during reset.
  - All data/meta fields 0.
  - tlast=0, tuser=0, counters 0, FSM=HDR.
- Reset asserted mid-packet aborts immediately. After release the block is in HDR, so the remainder of an in-flight host packet is parsed as a header; the host flushes H2C on reset.

## Configuration
- Macro: XDMA_H2C_SPLIT_STATS_EN.
- Defined: drop_cnt and len_err_cnt are implemented as saturating 16-bit registers.
- Undefined: no counter registers exist; both outputs are tied to 16'd0. The FSM behaviour is unchanged.

## Test plan
- **Normal packet:** header len=100 plus 2 payload beats (keep all-ones, then 36 bytes with tlast). Required response:
  - One meta with len=100.
  - 2 output beats; the second has tkeep=0x0000000FFFFFFFFF, tlast=1, tuser=0.
- **Trim:** header len=64 plus 3 payload beats. Required response:
  - Output is 1 beat with tlast=1 and full keep.
  - The remaining 2 input beats are swallowed.
  - The next header is parsed correctly.
- **Short packet:** header len=200 plus 1 beat of 64 bytes with tlast. Required response:
  - Output beat has tlast=1, tuser=1.
  - len_err_cnt=1 (stats build).
- **Illegal headers:**
  - len=0 followed by 2 beats: all dropped, drop_cnt=1, no meta.
  - Header-only beat with tlast=1: dropped, drop_cnt=2.
  - len=9000: dropped, drop_cnt=3.
- **Backpressure:** m_axis_tready toggling 50% and meta_ready held low for 20 cycles. Required response:
  - Payload is delivered in order, unchanged.
  - The second packet's header is stalled (s_axis_tready=0) until meta_ready is asserted.
- **Reset mid-packet:** assert xdma_reset during PAY. Required response:
  - Outputs are 0 in the same cycle.
  - After release, a fresh legal packet is processed normally.

Source files
------------

// File: rtl/xdma_h2c_udp_meta_splitter.sv
// Splits the XDMA H2C stream into UDP metadata (from a leading header beat) and a trimmed payload stream.
// Optional drop/length-error statistics are enabled by defining XDMA_H2C_SPLIT_STATS_EN.
module xdma_h2c_udp_meta_splitter #(
  parameter int DATA_WIDTH        = 512,
  parameter int KEEP_WIDTH        = DATA_WIDTH / 8,
  parameter int MAX_PAYLOAD_BYTES = 8192
) (
  input  logic                  xdma_clk,
  input  logic                  xdma_reset,

  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,

  output logic                  meta_valid,
  input  logic                  meta_ready,
  output logic [31:0]           meta_dst_ip,
  output logic [15:0]           meta_dst_port,
  output logic [15:0]           meta_src_port,
  output logic [15:0]           meta_len,

  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tuser,

  output logic [15:0]           drop_cnt,
  output logic [15:0]           len_err_cnt
);

  localparam int          PC_W    = $clog2(KEEP_WIDTH) + 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD_BYTES);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PAY  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [15:0]           byte_cnt_reg;
  logic                  meta_valid_reg;
  logic [31:0]           meta_dst_ip_reg;
  logic [15:0]           meta_dst_port_reg;
  logic [15:0]           meta_src_port_reg;
  logic [15:0]           meta_len_reg;

  logic                  m_valid_reg;
  logic                  m_last_reg;
  logic                  m_user_reg;
  logic [DATA_WIDTH-1:0] m_data_reg;
  logic [KEEP_WIDTH-1:0] m_keep_reg;

  logic [PC_W-1:0]       keep_cnt;
  logic [15:0]           byte_cnt_sum;
  logic [15:0]           remain;
  logic [KEEP_WIDTH-1:0] trim_mask;
  logic [15:0]           hdr_len;
  logic                  hdr_legal;

  logic                  s_ready_int;
  logic                  hdr_take;
  logic                  pay_take;
  logic                  drop_inc;
  logic                  len_err_inc;
  logic                  out_last;
  logic                  out_user;
  logic [KEEP_WIDTH-1:0] out_keep;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_cnt = keep_cnt + PC_W'(s_axis_tkeep[i]);
    end
  end

  assign byte_cnt_sum = byte_cnt_reg + 16'(keep_cnt);
  assign remain       = meta_len_reg - byte_cnt_reg;
  assign hdr_len      = s_axis_tdata[79:64];
  assign hdr_legal    = ~s_axis_tlast && (hdr_len != 16'd0) && (hdr_len <= MAX_LEN);

  // Keeps only the first (meta_len - byte_cnt) bytes of the closing beat.
  genvar gi;
  generate
    for (gi = 0; gi < KEEP_WIDTH; gi++) begin : g_trim
      assign trim_mask[gi] = (remain > 16'(gi));
    end
  endgenerate

  always_ff @(posedge xdma_clk or posedge xdma_reset) begin
    if (xdma_reset) begin
      state_reg <= HDR;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    s_ready_int = 1'b0;
    hdr_take    = 1'b0;
    pay_take    = 1'b0;
    drop_inc    = 1'b0;
    len_err_inc = 1'b0;
    out_last    = 1'b0;
    out_user    = 1'b0;
    out_keep    = s_axis_tkeep;
    case (state_reg)
      HDR: begin
        s_ready_int = ~meta_valid_reg;
        if (s_axis_tvalid && s_ready_int) begin
          if (hdr_legal) begin
            hdr_take   = 1'b1;
            state_next = PAY;
          end else begin
            drop_inc = 1'b1;
            if (!s_axis_tlast) begin
              state_next = DROP;
            end
          end
        end
      end
      PAY: begin
        s_ready_int = ~m_valid_reg | m_axis_tready;
        if (s_axis_tvalid && s_ready_int) begin
          pay_take = 1'b1;
          if (byte_cnt_sum >= meta_len_reg) begin
            out_last   = 1'b1;
            out_keep   = s_axis_tkeep & trim_mask;
            state_next = s_axis_tlast ? HDR : DROP;
          end else if (s_axis_tlast) begin
            out_last    = 1'b1;
            out_user    = 1'b1;
            len_err_inc = 1'b1;
            state_next  = HDR;
          end
        end
      end
      DROP: begin
        s_ready_int = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_next = HDR;
        end
      end
      default: begin
        state_next = HDR;
      end
    endcase
  end

  // Held low throughout reset even though HDR would otherwise advertise ready.
  assign s_axis_tready = s_ready_int & ~xdma_reset;

  always_ff @(posedge xdma_clk or posedge xdma_reset) begin
    if (xdma_reset) begin
      byte_cnt_reg      <= '0;
      meta_valid_reg    <= 1'b0;
      meta_dst_ip_reg   <= '0;
      meta_dst_port_reg <= '0;
      meta_src_port_reg <= '0;
      meta_len_reg      <= '0;
    end else begin
      if (hdr_take) begin
        meta_valid_reg    <= 1'b1;
        meta_dst_ip_reg   <= s_axis_tdata[31:0];
        meta_dst_port_reg <= s_axis_tdata[47:32];
        meta_src_port_reg <= s_axis_tdata[63:48];
        meta_len_reg      <= hdr_len;
        byte_cnt_reg      <= '0;
      end else begin
        if (meta_valid_reg && meta_ready) begin
          meta_valid_reg <= 1'b0;
        end
        if (pay_take) begin
          byte_cnt_reg <= byte_cnt_sum;
        end
      end
    end
  end

  always_ff @(posedge xdma_clk or posedge xdma_reset) begin
    if (xdma_reset) begin
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
      m_user_reg  <= 1'b0;
      m_data_reg  <= '0;
      m_keep_reg  <= '0;
    end else if (pay_take) begin
      m_valid_reg <= 1'b1;
      m_last_reg  <= out_last;
      m_user_reg  <= out_user;
      m_data_reg  <= s_axis_tdata;
      m_keep_reg  <= out_keep;
    end else if (m_axis_tready) begin
      m_valid_reg <= 1'b0;
    end
  end

`ifdef XDMA_H2C_SPLIT_STATS_EN
  logic [15:0] drop_cnt_reg;
  logic [15:0] len_err_cnt_reg;

  always_ff @(posedge xdma_clk or posedge xdma_reset) begin
    if (xdma_reset) begin
      drop_cnt_reg    <= '0;
      len_err_cnt_reg <= '0;
    end else begin
      if (drop_inc && (drop_cnt_reg != 16'hFFFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
      if (len_err_inc && (len_err_cnt_reg != 16'hFFFF)) begin
        len_err_cnt_reg <= len_err_cnt_reg + 16'd1;
      end
    end
  end

  assign drop_cnt    = drop_cnt_reg;
  assign len_err_cnt = len_err_cnt_reg;
`else
  logic unused_stats;
  assign unused_stats = &{1'b0, drop_inc, len_err_inc};
  assign drop_cnt     = 16'd0;
  assign len_err_cnt  = 16'd0;
`endif

  assign meta_valid    = meta_valid_reg;
  assign meta_dst_ip   = meta_dst_ip_reg;
  assign meta_dst_port = meta_dst_port_reg;
  assign meta_src_port = meta_src_port_reg;
  assign meta_len      = meta_len_reg;

  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tlast  = m_last_reg;
  assign m_axis_tuser  = m_user_reg;
  assign m_axis_tdata  = m_data_reg;
  assign m_axis_tkeep  = m_keep_reg;

endmodule

// File: tb/tb_xdma_h2c_udp_meta_splitter.sv
// Directed bench for the H2C UDP meta splitter: scoreboard of expected meta and payload beats.
module tb_xdma_h2c_udp_meta_splitter;

  logic         xdma_clk;
  logic         xdma_reset;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         meta_valid;
  logic         meta_ready;
  logic [31:0]  meta_dst_ip;
  logic [15:0]  meta_dst_port;
  logic [15:0]  meta_src_port;
  logic [15:0]  meta_len;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tuser;
  logic [15:0]  drop_cnt;
  logic [15:0]  len_err_cnt;

  xdma_h2c_udp_meta_splitter dut (
    .xdma_clk      (xdma_clk),
    .xdma_reset    (xdma_reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .meta_valid    (meta_valid),
    .meta_ready    (meta_ready),
    .meta_dst_ip   (meta_dst_ip),
    .meta_dst_port (meta_dst_port),
    .meta_src_port (meta_src_port),
    .meta_len      (meta_len),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .drop_cnt      (drop_cnt),
    .len_err_cnt   (len_err_cnt)
  );

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
    logic         u;
  } beat_t;

  beat_t        exp_beats[$];
  logic [79:0]  exp_meta[$];
  int           compared = 0;
  int           mismatched = 0;
  int           exp_drop = 0;
  int           exp_lenerr = 0;
  int           ready_mode = 0;
  bit           meta_hold = 0;

  initial xdma_clk = 1'b0;
  always #5 xdma_clk = ~xdma_clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] kmask(input int n);
    logic [63:0] m;
    if (n >= 64) m = '1;
    else m = (64'd1 << n) - 64'd1;
    return m;
  endfunction

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Sink-side ready generation, updated just after each rising edge.
  always begin
    @(posedge xdma_clk);
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
    meta_ready = ~meta_hold;
  end

  always @(negedge xdma_clk) begin
    if (!xdma_reset && m_axis_tvalid && m_axis_tready) begin
      if (exp_beats.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        beat_t e;
        e = exp_beats.pop_front();
        chk("beat_data", m_axis_tdata, e.d);
        chk("beat_keep", m_axis_tkeep, e.k);
        chk("beat_last", m_axis_tlast, e.l);
        if (e.l) chk("beat_user", m_axis_tuser, e.u);
        $display("beat keep=%h last=%0d user=%0d", m_axis_tkeep, m_axis_tlast, m_axis_tuser);
      end
    end
    if (!xdma_reset && meta_valid && meta_ready) begin
      if (exp_meta.size() == 0) begin
        chk("unexpected_meta", 1, 0);
      end else begin
        logic [79:0] em;
        em = exp_meta.pop_front();
        chk("meta_fields", {meta_len, meta_src_port, meta_dst_port, meta_dst_ip}, em);
        $display("meta len=%0d ip=%h", meta_len, meta_dst_ip);
      end
    end
  end

  // Drives one beat starting just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input bit l);
    int t;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    t = 0;
    forever begin
      @(negedge xdma_clk);
      if (s_axis_tready) break;
      t++;
      if (t > 300) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge xdma_clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_packet(input logic [15:0] len, input int nb, input int lastn, input bit hdr_last);
    logic [511:0] hdr;
    logic [511:0] d;
    logic [63:0]  k;
    bit           legal;
    bit           dropping;
    int           cnt;
    int           nbytes;
    beat_t        e;
    hdr = '0;
    hdr[31:0]  = $urandom;
    hdr[47:32] = 16'($urandom);
    hdr[63:48] = 16'($urandom);
    hdr[79:64] = len;
    legal = !hdr_last && (len != 0) && (len <= 8192);
    if (legal) exp_meta.push_back(hdr[79:0]);
    else exp_drop++;
    send_beat(hdr, '1, hdr_last);
    if (hdr_last) return;
    dropping = !legal;
    cnt = 0;
    for (int i = 0; i < nb; i++) begin
      nbytes = (i == nb - 1) ? lastn : 64;
      k = kmask(nbytes);
      d = rand_data();
      if (!dropping) begin
        e.d = d;
        if (cnt + nbytes >= int'(len)) begin
          e.k = k & kmask(int'(len) - cnt);
          e.l = 1'b1;
          e.u = 1'b0;
          dropping = 1;
        end else if (i == nb - 1) begin
          e.k = k;
          e.l = 1'b1;
          e.u = 1'b1;
          exp_lenerr++;
        end else begin
          e.k = k;
          e.l = 1'b0;
          e.u = 1'b0;
        end
        exp_beats.push_back(e);
        cnt += nbytes;
      end
      send_beat(d, k, i == nb - 1);
    end
  endtask

  task automatic drain_and_check(input string tag);
    int t;
    t = 0;
    while ((exp_beats.size() != 0 || exp_meta.size() != 0) && t < 500) begin
      @(negedge xdma_clk);
      t++;
    end
    repeat (3) @(negedge xdma_clk);
    chk({tag, "_beats_left"}, exp_beats.size(), 0);
    chk({tag, "_meta_left"}, exp_meta.size(), 0);
`ifdef XDMA_H2C_SPLIT_STATS_EN
    chk({tag, "_drop_cnt"}, drop_cnt, exp_drop);
    chk({tag, "_len_err_cnt"}, len_err_cnt, exp_lenerr);
`else
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
    chk({tag, "_len_err_cnt"}, len_err_cnt, 0);
`endif
    @(posedge xdma_clk);
    #1;
  endtask

  initial begin
    xdma_reset    = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    m_axis_tready = 1'b0;
    meta_ready    = 1'b0;

    repeat (3) @(negedge xdma_clk);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_meta_valid", meta_valid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_meta_len", meta_len, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(posedge xdma_clk);
    #1;
    xdma_reset = 1'b0;
    repeat (2) @(posedge xdma_clk);
    #1;

    send_packet(16'd100, 2, 36, 0);
    drain_and_check("normal");

    send_packet(16'd64, 3, 64, 0);
    send_packet(16'd128, 2, 64, 0);
    drain_and_check("trim");

    send_packet(16'd200, 1, 64, 0);
    drain_and_check("short");

    send_packet(16'd0, 2, 64, 0);
    send_packet(16'd50, 0, 0, 1);
    send_packet(16'd9000, 1, 64, 0);
    send_packet(16'd8192, 128, 64, 0);
    drain_and_check("illegal");

    meta_hold  = 1;
    ready_mode = 1;
    @(posedge xdma_clk);
    #1;
    send_packet(16'd300, 5, 44, 0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tdata[79:64] = 16'd10;
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge xdma_clk);
      chk("hdr_stall", s_axis_tready, 0);
    end
    @(posedge xdma_clk);
    #1;
    s_axis_tvalid = 1'b0;
    meta_hold = 0;
    send_packet(16'd130, 3, 2, 0);
    send_packet(16'd64, 1, 64, 0);
    drain_and_check("backpressure");
    ready_mode = 0;

    meta_hold  = 1;
    @(posedge xdma_clk);
    #1;
    send_packet(16'd300, 0, 0, 0);
    ready_mode = 2;
    @(posedge xdma_clk);
    #1;
    send_beat(rand_data(), '1, 0);
    @(negedge xdma_clk);
    chk("pre_rst_m_tvalid", m_axis_tvalid, 1);
    xdma_reset = 1'b1;
    #1;
    chk("midrst_m_tvalid", m_axis_tvalid, 0);
    chk("midrst_meta_valid", meta_valid, 0);
    chk("midrst_s_tready", s_axis_tready, 0);
    chk("midrst_m_tdata", m_axis_tdata, 0);
    chk("midrst_m_tkeep", m_axis_tkeep, 0);
    exp_beats.delete();
    exp_meta.delete();
    exp_drop   = 0;
    exp_lenerr = 0;
    meta_hold  = 0;
    ready_mode = 0;
    @(posedge xdma_clk);
    #1;
    xdma_reset = 1'b0;
    @(posedge xdma_clk);
    #1;
    send_packet(16'd100, 2, 36, 0);
    drain_and_check("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
